cia_timer_gen: RTL and testbench
================================

Name: cia_timer_gen

Overview:
Generalised CIA interval timer, the successor to the fixed 16-bit timer B. Provides:
- Parametrised counter width.
- Four count-source modes: E-clock, CNT rising edge, cascade underflow, cascade underflow gated by CNT.
- Optional PB output in pulse or toggle form.
Instantiated once per timer channel inside the CIA wrapper. The wrapper decodes registers and merges irq into ICR.

Parameters:
TMR_BYTES, 2, counter width in bytes (1..4); counter width W = 8*TMR_BYTES
LOAD_ON_TOP, 1, 1 = writing the top latch byte loads the counter when stopped or in one-shot mode; 0 = only the force-load strobe or an underflow loads it

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset, sampled only when clk7_en=1
clk7_en  in  1  7 MHz clock enable; all state advances only when high
wr  in  1  bus write (0 = read)
tsel  in  TMR_BYTES  one-hot byte select for timer bytes; bit i = bits [8i+7:8i]
tcr  in  1  control register select
data_in  in  8  bus write data
data_out  out  8  read data; 0 when no select is active or wr=1
eclk  in  1  E-clock count enable pulse
cnt  in  1  CNT pin level, synchronised upstream
cas_ovf  in  1  underflow pulse of the preceding timer
irq  out  1  underflow pulse (one clk7_en cycle)
ovf  out  1  same as irq; cascade output to the next timer
pb_out  out  1  PB pin drive value; 0 when PBON=0

Behaviour:
- Clock and reset: one clock (clk, qualified by clk7_en); reset is synchronous and active-high, as fixed for this block.
- Control register (8 bits, stored bits 6:0): [0] START, [1] PBON, [2] OUTMODE (0 pulse, 1 toggle), [3] RUNMODE (1 one-shot), [4] LOAD (strobe, never stored, reads 0), [6:5] INMODE. Bit 7 reads 0.
- Reset: counter = all ones; latches = all ones; control = 0; toggle flop = 0; cnt_d = 0; irq = ovf = pb_out = 0.
- INMODE count select:
  - 00: eclk
  - 01: cnt & ~cnt_d; cnt_d is cnt registered on clk7_en
  - 10: cas_ovf
  - 11: cas_ovf & cnt
- underflow = (counter==0) & START & count, combinational. irq = ovf = underflow.
- forceload is registered: a tcr write with data_in[4]=1 asserts forceload on the next clk7_en cycle.
- topload is registered: a write to byte TMR_BYTES-1 with LOAD_ON_TOP=1 and (START=0 or RUNMODE=1) asserts topload on the next clk7_en cycle.
- Counter priority each clk7_en: reset > (topload | forceload | underflow) load from latches > (START & count) decrement by 1 > hold. Decrement never wraps; underflow reloads instead.
- Control update priority: reset > tcr write (bit 4 forced 0) > topload & RUNMODE sets START > underflow & RUNMODE clears START.
- Latch bytes: writing byte i updates latch byte i only. The counter is unaffected until the next load.
- Reads: tsel byte i returns live counter byte i; tcr returns {1'b0, ctrl[6:0]}. Exactly one select is asserted per access; multiple selects are OR-combined.
- PB output:
  - Pulse mode: pb_out = PBON & underflow.
  - Toggle mode: the toggle flop inverts on each underflow and is set to 1 on any START 0->1 transition, from either a write or topload. pb_out = PBON & toggle.
- Simultaneous events:
  - tcr write clearing START in the same cycle as underflow: the write wins, START=0, and the counter reloads.
  - Latch write in the same cycle as underflow: the reload uses the old latch value.
  - Reset during counting: everything returns to reset values immediately. irq stays 0 until START is set again.
- clk7_en=0: all registers hold and all edge detection is frozen.

Optional Feature:
CIA_TIMER_READLATCH_EN.
- Defined: reading the top byte snapshots the lower W-8 counter bits into a read-hold register. Reads of lower bytes return the snapshot until the next top-byte read or reset. This gives coherent multi-byte reads.
- Not defined: all reads return live counter bytes, with no extra registers.

Test Plan:
1. Reset, then read all bytes and tcr -> timer bytes = 0xFF, tcr = 0x00, irq = 0, pb_out = 0.
2. TMR_BYTES=2: write lo=0x03, hi=0x00 with RUNMODE=1 and eclk=1 continuously -> counter loads 0x0003 and START sets. Counter steps 3,2,1,0, then irq pulses once and the counter reloads 0x0003. START reads 0 afterwards.
3. Continuous mode, latch 0x0002, OUTMODE=1, PBON=1, eclk=1 -> pb_out is 1 at start and toggles on each underflow, every 3 counts.
4. INMODE=01, latch 0x0001, START -> counter decrements only on cnt rising edges. Holding cnt high produces a single decrement.
5. INMODE=11, cas_ovf pulses with cnt=0, then cnt=1 -> counting occurs only while cnt=1. Also verify tcr write with START=0 coinciding with underflow leaves START=0 and the counter reloaded.
6. TMR_BYTES=3, LOAD_ON_TOP=0: write the top byte while stopped -> counter is unchanged. A tcr write with LOAD=1 loads it on the following cycle and LOAD reads back 0.

Source files
------------

// File: rtl/cia_timer_gen_if.sv
// cia_timer_gen_if -- register bus between the CIA wrapper and one timer channel.
//
// Signals:
//   wr        bus write strobe (0 = read)
//   tsel      one-hot timer byte select, bit i = counter/latch bits [8i+7:8i]
//   tcr       control register select
//   data_in   write data
//   data_out  read data from the timer (0 when nothing is selected or wr=1)
//
// Modports: master = register decoder / bench, slave = timer channel.
interface cia_timer_gen_if #(
  parameter int TMR_BYTES = 2
);
  logic                 wr;
  logic [TMR_BYTES-1:0] tsel;
  logic                 tcr;
  logic [7:0]           data_in;
  logic [7:0]           data_out;

  modport master (output wr, tsel, tcr, data_in, input data_out);
  modport slave  (input wr, tsel, tcr, data_in, output data_out);
endinterface

// File: rtl/cia_timer_gen.sv
// cia_timer_gen -- generalised CIA interval timer channel.
//
// A down-counter of 8*TMR_BYTES bits with per-byte reload latches, a control
// register and four count sources (E-clock, CNT rising edge, cascade
// underflow, cascade underflow gated by CNT). Underflow reloads the counter,
// pulses irq/ovf and optionally drives PB in pulse or toggle form.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (sampled on clk7_en)
//   clk7_en      7 MHz enable; every register advances only when high
//   bus          register bus (cia_timer_gen_if.slave)
//   eclk         E-clock count pulse
//   cnt          CNT pin level (already synchronised)
//   cas_ovf      underflow pulse of the preceding timer
//   irq, ovf     underflow pulse (combinational)
//   pb_out       PB pin drive value
//
// Optional build macro: CIA_TIMER_READLATCH_EN -- reading the top byte
// snapshots the lower counter bytes so multi-byte reads are coherent.
module cia_timer_gen #(
  parameter int TMR_BYTES   = 2,
  parameter bit LOAD_ON_TOP = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk7_en,
  cia_timer_gen_if.slave  bus,
  input  logic            eclk,
  input  logic            cnt,
  input  logic            cas_ovf,
  output logic            irq,
  output logic            ovf,
  output logic            pb_out
);
  localparam int W   = 8 * TMR_BYTES;
  localparam int TOP = TMR_BYTES - 1;

  // ctrl_reg: [0] START [1] PBON [2] OUTMODE [3] RUNMODE [4] unused(0) [6:5] INMODE
  logic [W-1:0]         counter_reg;
  logic [7:0]           latch_reg [TMR_BYTES];
  logic [6:0]           ctrl_reg;
  logic [6:0]           ctrl_next;
  logic                 toggle_reg;
  logic                 cnt_d_reg;
  logic                 forceload_reg;
  logic                 topload_reg;

  logic [W-1:0]         latch_val;
  logic [W-1:0]         rd_src;
  logic [7:0]           rd_byte [TMR_BYTES];
  logic [7:0]           data_rd;
  logic [TMR_BYTES-1:0] byte_wr;
  logic                 tcr_wr;
  logic                 top_wr;
  logic                 count_en;
  logic                 underflow;
  logic                 load;

  assign tcr_wr = bus.wr & bus.tcr;
  assign top_wr = byte_wr[TOP];

  // Count source selected by INMODE.
  always_comb begin
    count_en = 1'b0;
    case (ctrl_reg[6:5])
      2'b00:   count_en = eclk;
      2'b01:   count_en = cnt & ~cnt_d_reg;
      2'b10:   count_en = cas_ovf;
      default: count_en = cas_ovf & cnt;
    endcase
  end

  assign underflow = (counter_reg == '0) & ctrl_reg[0] & count_en;
  assign load      = topload_reg | forceload_reg | underflow;
  assign irq       = underflow;
  assign ovf       = underflow;
  assign pb_out    = ctrl_reg[1] & (ctrl_reg[2] ? toggle_reg : underflow);

  // A tcr write overrides the automatic START changes, so a write clearing
  // START in the underflow cycle leaves the timer stopped (but reloaded).
  always_comb begin
    ctrl_next = ctrl_reg;
    if (tcr_wr) begin
      ctrl_next = {bus.data_in[6:5], 1'b0, bus.data_in[3:0]};
    end else if (topload_reg && ctrl_reg[3]) begin
      ctrl_next[0] = 1'b1;
    end else if (underflow && ctrl_reg[3]) begin
      ctrl_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        counter_reg   <= '1;
        ctrl_reg      <= '0;
        toggle_reg    <= 1'b0;
        cnt_d_reg     <= 1'b0;
        forceload_reg <= 1'b0;
        topload_reg   <= 1'b0;
      end else begin
        cnt_d_reg     <= cnt;
        forceload_reg <= tcr_wr & bus.data_in[4];
        topload_reg   <= LOAD_ON_TOP & top_wr & (~ctrl_reg[0] | ctrl_reg[3]);
        ctrl_reg      <= ctrl_next;
        // Load uses the latch contents before any same-cycle latch write.
        if (load) begin
          counter_reg <= latch_val;
        end else if (ctrl_reg[0] && count_en) begin
          counter_reg <= counter_reg - {{(W-1){1'b0}}, 1'b1};
        end
        // START 0->1 presets the toggle; underflow cannot coincide with it
        // because underflow needs START already set.
        if (!ctrl_reg[0] && ctrl_next[0]) begin
          toggle_reg <= 1'b1;
        end else if (underflow) begin
          toggle_reg <= ~toggle_reg;
        end
      end
    end
  end

  // Per-byte latch storage and read select.
  genvar gi;
  generate
    for (gi = 0; gi < TMR_BYTES; gi++) begin : g_byte
      assign byte_wr[gi] = bus.wr & bus.tsel[gi];

      always_ff @(posedge clk) begin
        if (clk7_en) begin
          if (reset) begin
            latch_reg[gi] <= 8'hFF;
          end else if (byte_wr[gi]) begin
            latch_reg[gi] <= bus.data_in;
          end
        end
      end

      assign latch_val[8*gi +: 8] = latch_reg[gi];
      assign rd_byte[gi] = (!bus.wr && bus.tsel[gi]) ? rd_src[8*gi +: 8] : 8'h00;
    end
  endgenerate

`ifdef CIA_TIMER_READLATCH_EN
  generate
    if (TMR_BYTES > 1) begin : g_hold
      logic [W-9:0] hold_reg;

      always_ff @(posedge clk) begin
        if (clk7_en) begin
          if (reset) begin
            hold_reg <= '1;
          end else if (!bus.wr && bus.tsel[TOP]) begin
            hold_reg <= counter_reg[W-9:0];
          end
        end
      end

      assign rd_src = {counter_reg[W-1:W-8], hold_reg};
    end else begin : g_no_hold
      assign rd_src = counter_reg;
    end
  endgenerate
`else
  assign rd_src = counter_reg;
`endif

  // Selects are OR-combined; bit 7 of the control register always reads 0.
  always_comb begin
    data_rd = (!bus.wr && bus.tcr) ? {1'b0, ctrl_reg} : 8'h00;
    for (int i = 0; i < TMR_BYTES; i++) begin
      data_rd = data_rd | rd_byte[i];
    end
  end

  assign bus.data_out = data_rd;
endmodule

// File: tb/tb_cia_timer_gen.sv
// tb_cia_timer_gen -- directed scoreboard bench for cia_timer_gen.
// dut  : TMR_BYTES=2, LOAD_ON_TOP=1 (one-shot, toggle, CNT edge, cascade tests)
// dut3 : TMR_BYTES=3, LOAD_ON_TOP=0 (top-byte write without load, force load)
module tb_cia_timer_gen;
  logic clk = 1'b0;
  logic reset, clk7_en, eclk, cnt, cas_ovf;
  logic irq_a, ovf_a, pb_a, irq_b, ovf_b, pb_b;

  always #5 clk = ~clk;

  cia_timer_gen_if #(.TMR_BYTES(2)) bif ();
  cia_timer_gen_if #(.TMR_BYTES(3)) bif3 ();

  cia_timer_gen #(.TMR_BYTES(2), .LOAD_ON_TOP(1'b1)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .bus(bif.slave),
    .eclk(eclk), .cnt(cnt), .cas_ovf(cas_ovf),
    .irq(irq_a), .ovf(ovf_a), .pb_out(pb_a)
  );

  cia_timer_gen #(.TMR_BYTES(3), .LOAD_ON_TOP(1'b0)) dut3 (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .bus(bif3.slave),
    .eclk(eclk), .cnt(cnt), .cas_ovf(cas_ovf),
    .irq(irq_b), .ovf(ovf_b), .pb_out(pb_b)
  );

  string       exp_tag_q[$];
  logic [31:0] exp_val_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  // Expected sequences
  logic [7:0] t2_lo  [6] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h03};
  logic       t2_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] t3_lo  [8] = '{8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01};
  logic       t3_pb  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       t3_irq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t4_cnt [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] t4_lo  [7] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic       t4_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t5_cas [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       t5_cnt [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] t5_lo  [10] = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 8'h01};
  logic       t5_irq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    n_vec++;
    if (exp_val_q.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      tag = exp_tag_q.pop_front();
      e   = exp_val_q.pop_front();
      $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, e);
      assert (obs === e) else begin
        n_miss++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] ts, input logic tc, input logic [7:0] d);
    bif.wr = 1'b1; bif.tsel = ts; bif.tcr = tc; bif.data_in = d;
    cyc();
    bif.wr = 1'b0; bif.tsel = '0; bif.tcr = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] ts, input logic tc, input logic [7:0] d);
    bif3.wr = 1'b1; bif3.tsel = ts; bif3.tcr = tc; bif3.data_in = d;
    cyc();
    bif3.wr = 1'b0; bif3.tsel = '0; bif3.tcr = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] ts, input logic tc, input string tag, input logic [7:0] e);
    bif.wr = 1'b0; bif.tsel = ts; bif.tcr = tc;
    expect_v(tag, {24'h0, e});
    #1;
    check_v({24'h0, bif.data_out});
    bif.tsel = '0; bif.tcr = 1'b0;
  endtask

  task automatic rd_b(input logic [2:0] ts, input logic tc, input string tag, input logic [7:0] e);
    bif3.wr = 1'b0; bif3.tsel = ts; bif3.tcr = tc;
    expect_v(tag, {24'h0, e});
    #1;
    check_v({24'h0, bif3.data_out});
    bif3.tsel = '0; bif3.tcr = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic e);
    expect_v(tag, {31'h0, e});
    check_v({31'h0, obs});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clk7_en = 1'b1; eclk = 1'b0; cnt = 1'b0; cas_ovf = 1'b0;
    bif.wr = 1'b0; bif.tsel = '0; bif.tcr = 1'b0; bif.data_in = '0;
    bif3.wr = 1'b0; bif3.tsel = '0; bif3.tcr = 1'b0; bif3.data_in = '0;
    cyc(); cyc(); cyc();
    reset = 1'b0;

    // 1: reset state
    rd_a(2'b10, 1'b0, "t1_hi", 8'hFF);
    rd_a(2'b01, 1'b0, "t1_lo", 8'hFF);
    rd_a(2'b00, 1'b1, "t1_tcr", 8'h00);
    cyc();
    chk_bit("t1_irq", irq_a, 1'b0);
    chk_bit("t1_pb", pb_a, 1'b0);
    rd_b(3'b100, 1'b0, "t1_b_top", 8'hFF);
    rd_b(3'b000, 1'b1, "t1_b_tcr", 8'h00);
    cyc();

    // 2: one-shot via top-byte load
    eclk = 1'b1;
    wr_a(2'b00, 1'b1, 8'h08);
    wr_a(2'b01, 1'b0, 8'h03);
    wr_a(2'b10, 1'b0, 8'h00);
    bif.tsel = 2'b01;
    for (int k = 0; k < 6; k++) begin
      expect_v($sformatf("t2_lo[%0d]", k), {24'h0, t2_lo[k]});
      expect_v($sformatf("t2_irq[%0d]", k), {31'h0, t2_irq[k]});
    end
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      check_v({24'h0, bif.data_out});
      check_v({31'h0, irq_a});
    end
    bif.tsel = '0;
    rd_a(2'b00, 1'b1, "t2_tcr_start_clr", 8'h08);
    cyc();

    // 3: continuous toggle mode on PB
    wr_a(2'b00, 1'b1, 8'h00);
    wr_a(2'b01, 1'b0, 8'h02);
    wr_a(2'b10, 1'b0, 8'h00);
    wr_a(2'b00, 1'b1, 8'h07);
    bif.tsel = 2'b01;
    for (int k = 0; k < 8; k++) begin
      expect_v($sformatf("t3_lo[%0d]", k), {24'h0, t3_lo[k]});
      expect_v($sformatf("t3_pb[%0d]", k), {31'h0, t3_pb[k]});
      expect_v($sformatf("t3_irq[%0d]", k), {31'h0, t3_irq[k]});
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      #1;
      check_v({24'h0, bif.data_out});
      check_v({31'h0, pb_a});
      check_v({31'h0, ovf_a});
    end
    bif.tsel = '0;
    wr_a(2'b00, 1'b1, 8'h00);

    // 4: CNT rising-edge counting
    cnt = 1'b0;
    wr_a(2'b01, 1'b0, 8'h01);
    wr_a(2'b10, 1'b0, 8'h00);
    wr_a(2'b00, 1'b1, 8'h21);
    bif.tsel = 2'b01;
    for (int k = 0; k < 7; k++) begin
      expect_v($sformatf("t4_lo[%0d]", k), {24'h0, t4_lo[k]});
      expect_v($sformatf("t4_irq[%0d]", k), {31'h0, t4_irq[k]});
    end
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      cnt = t4_cnt[k];
      #1;
      check_v({24'h0, bif.data_out});
      check_v({31'h0, irq_a});
    end
    bif.tsel = '0;
    cnt = 1'b0;
    wr_a(2'b00, 1'b1, 8'h00);

    // 5: cascade gated by CNT, then stop-write coinciding with underflow
    wr_a(2'b01, 1'b0, 8'h02);
    wr_a(2'b10, 1'b0, 8'h00);
    wr_a(2'b00, 1'b1, 8'h61);
    bif.tsel = 2'b01;
    for (int k = 0; k < 10; k++) begin
      expect_v($sformatf("t5_lo[%0d]", k), {24'h0, t5_lo[k]});
      expect_v($sformatf("t5_irq[%0d]", k), {31'h0, t5_irq[k]});
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      cas_ovf = t5_cas[k];
      cnt     = t5_cnt[k];
      #1;
      check_v({24'h0, bif.data_out});
      check_v({31'h0, irq_a});
    end
    cyc();
    cas_ovf = 1'b1; cnt = 1'b1;
    bif.tsel = '0; bif.wr = 1'b1; bif.tcr = 1'b1; bif.data_in = 8'h60;
    #1;
    chk_bit("t5_coincide_irq", irq_a, 1'b1);
    cyc();
    bif.wr = 1'b0; bif.tcr = 1'b0;
    rd_a(2'b01, 1'b0, "t5_reloaded", 8'h02);
    rd_a(2'b00, 1'b1, "t5_tcr_stopped", 8'h60);
    cyc();
    rd_a(2'b01, 1'b0, "t5_held", 8'h02);
    chk_bit("t5_irq_stopped", irq_a, 1'b0);
    cas_ovf = 1'b0; cnt = 1'b0;
    cyc();

    // 6: LOAD_ON_TOP=0 and force load on the 3-byte timer
    wr_b(3'b100, 1'b0, 8'h12);
    cyc();
    rd_b(3'b100, 1'b0, "t6_top_unchanged", 8'hFF);
    rd_b(3'b001, 1'b0, "t6_lo_unchanged", 8'hFF);
    cyc();
    wr_b(3'b001, 1'b0, 8'h34);
    wr_b(3'b010, 1'b0, 8'h56);
    wr_b(3'b000, 1'b1, 8'h10);
    rd_b(3'b100, 1'b0, "t6_before_load", 8'hFF);
    cyc();
    rd_b(3'b100, 1'b0, "t6_top_loaded", 8'h12);
    rd_b(3'b010, 1'b0, "t6_mid_loaded", 8'h56);
    rd_b(3'b001, 1'b0, "t6_lo_loaded", 8'h34);
    cyc();
    rd_b(3'b000, 1'b1, "t6_tcr_load_reads0", 8'h00);
    chk_bit("t6_irq", irq_b, 1'b0);
    cyc();

    // 7: reset while counting
    wr_a(2'b00, 1'b1, 8'h01);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_a(2'b10, 1'b0, "t7_hi", 8'hFF);
    rd_a(2'b01, 1'b0, "t7_lo", 8'hFF);
    rd_a(2'b00, 1'b1, "t7_tcr", 8'h00);
    cyc();
    rd_a(2'b01, 1'b0, "t7_lo_idle", 8'hFF);
    chk_bit("t7_irq", irq_a, 1'b0);
    chk_bit("t7_pb", pb_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
